// File: rtl/sd_init_sequencer_if.sv
// Command request/completion bundle between the SD init sequencer (master)
// and the CMD-line engine (slave). Member names follow the sequencer's view.
interface sd_init_sequencer_if;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic [1:0]  cmd_resp_o;
  logic        cmd_done_i;
  logic        cmd_timeout_i;
  logic [31:0] cmd_resp_i;

  modport master (
    output cmd_valid_o, cmd_index_o, cmd_arg_o, cmd_resp_o,
    input  cmd_ready_i, cmd_done_i, cmd_timeout_i, cmd_resp_i
  );

  modport slave (
    input  cmd_valid_o, cmd_index_o, cmd_arg_o, cmd_resp_o,
    output cmd_ready_i, cmd_done_i, cmd_timeout_i, cmd_resp_i
  );
endinterface

// File: rtl/sd_init_sequencer.sv
// SD card identification sequencer: CMD0, CMD8, CMD55/ACMD41 polling loop.
// Optional `SD_INIT_RCA_EN adds CMD2/CMD3 and captures the relative card address.
module sd_init_sequencer #(
  parameter int unsigned RETRY_WAIT_CYCLES = 5000000,
  parameter int unsigned MAX_ATTEMPTS      = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  sd_init_sequencer_if.master cmd,
  output logic                busy_o,
  output logic                init_done_o,
  output logic                init_err_o,
  output logic [2:0]          err_code_o,
  output logic                ccs_o,
  output logic [15:0]         attempts_o,
  output logic [15:0]         rca_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD0,
    S_CMD8,
    S_CMD55,
    S_ACMD41,
    S_RETRY_WAIT,
`ifdef SD_INIT_RCA_EN
    S_CMD2,
    S_CMD3,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {PH_SETUP, PH_REQ, PH_WAIT} phase_e;

  typedef enum logic [2:0] {
    E_NONE, E_CMD8_ECHO, E_CMD55_TO, E_ACMD41_TO, E_ATTEMPTS, E_ID_TO
  } err_e;

  localparam logic [31:0] RETRY_LOAD = 32'(RETRY_WAIT_CYCLES - 1);
  localparam logic [15:0] MAX_ATT    = 16'(MAX_ATTEMPTS);

  state_e      state_q;
  phase_e      phase_q;
  err_e        err_q;
  logic        valid_q, busy_q, done_q, fail_q, ccs_q, hcs_q;
  logic [5:0]  index_q, index_d;
  logic [31:0] arg_q, arg_d;
  logic [1:0]  resp_q, resp_d;
  logic [15:0] attempts_q;
  logic [31:0] wait_cnt_q;
  logic        unused_resp_bits;

  always_comb begin
    index_d = '0;
    arg_d   = '0;
    resp_d  = 2'd1;
    case (state_q)
      S_CMD0:   resp_d  = 2'd0;
      S_CMD8:   begin index_d = 6'd8;  arg_d = 32'h0000_01AA; end
      S_CMD55:  index_d = 6'd55;
      S_ACMD41: begin
        index_d = 6'd41;
        arg_d   = hcs_q ? 32'h4030_0000 : 32'h0030_0000;
      end
`ifdef SD_INIT_RCA_EN
      S_CMD2:   begin index_d = 6'd2; resp_d = 2'd2; end
      S_CMD3:   index_d = 6'd3;
`endif
      default:  resp_d  = 2'd0;
    endcase
  end

`ifdef SD_INIT_RCA_EN
  logic [15:0] rca_q;
  localparam state_e S_AFTER_ACMD41 = S_CMD2;
`else
  localparam state_e S_AFTER_ACMD41 = S_DONE;
`endif

  // Every command state runs SETUP (drive fields) -> REQ (hold valid) -> WAIT (done).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_SETUP;
      err_q      <= E_NONE;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      ccs_q      <= 1'b0;
      hcs_q      <= 1'b0;
      index_q    <= '0;
      arg_q      <= '0;
      resp_q     <= '0;
      attempts_q <= '0;
      wait_cnt_q <= '0;
`ifdef SD_INIT_RCA_EN
      rca_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_q    <= S_CMD0;
            phase_q    <= PH_SETUP;
            err_q      <= E_NONE;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            ccs_q      <= 1'b0;
            hcs_q      <= 1'b0;
            attempts_q <= '0;
`ifdef SD_INIT_RCA_EN
            rca_q      <= '0;
`endif
          end
        end
        S_RETRY_WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q <= S_CMD55;
            phase_q <= PH_SETUP;
          end else begin
            wait_cnt_q <= wait_cnt_q - 32'd1;
          end
        end
        default: begin
          case (phase_q)
            PH_SETUP: begin
              valid_q <= 1'b1;
              index_q <= index_d;
              arg_q   <= arg_d;
              resp_q  <= resp_d;
              phase_q <= PH_REQ;
            end
            PH_REQ: begin
              if (cmd.cmd_ready_i) begin
                valid_q <= 1'b0;
                phase_q <= PH_WAIT;
                if (state_q == S_ACMD41) attempts_q <= attempts_q + 16'd1;
              end
            end
            default: begin
              if (cmd.cmd_done_i) begin
                phase_q <= PH_SETUP;
                case (state_q)
                  S_CMD0: state_q <= S_CMD8;
                  S_CMD8: begin
                    if (cmd.cmd_timeout_i || cmd.cmd_resp_i[11:0] == 12'h1AA) begin
                      hcs_q   <= !cmd.cmd_timeout_i;
                      state_q <= S_CMD55;
                    end else begin
                      err_q <= E_CMD8_ECHO; state_q <= S_ERROR; busy_q <= 1'b0; fail_q <= 1'b1;
                    end
                  end
                  S_CMD55: begin
                    if (cmd.cmd_timeout_i) begin
                      err_q <= E_CMD55_TO; state_q <= S_ERROR; busy_q <= 1'b0; fail_q <= 1'b1;
                    end else begin
                      state_q <= S_ACMD41;
                    end
                  end
                  S_ACMD41: begin
                    if (cmd.cmd_timeout_i) begin
                      err_q <= E_ACMD41_TO; state_q <= S_ERROR; busy_q <= 1'b0; fail_q <= 1'b1;
                    end else if (cmd.cmd_resp_i[31]) begin
                      ccs_q   <= cmd.cmd_resp_i[30];
                      state_q <= S_AFTER_ACMD41;
                      if (S_AFTER_ACMD41 == S_DONE) begin
                        busy_q <= 1'b0; done_q <= 1'b1;
                      end
                    end else if (attempts_q == MAX_ATT) begin
                      err_q <= E_ATTEMPTS; state_q <= S_ERROR; busy_q <= 1'b0; fail_q <= 1'b1;
                    end else begin
                      wait_cnt_q <= RETRY_LOAD;
                      state_q    <= S_RETRY_WAIT;
                    end
                  end
`ifdef SD_INIT_RCA_EN
                  S_CMD2, S_CMD3: begin
                    if (cmd.cmd_timeout_i) begin
                      err_q <= E_ID_TO; state_q <= S_ERROR; busy_q <= 1'b0; fail_q <= 1'b1;
                    end else if (state_q == S_CMD2) begin
                      state_q <= S_CMD3;
                    end else begin
                      rca_q   <= cmd.cmd_resp_i[31:16];
                      state_q <= S_DONE; busy_q <= 1'b0; done_q <= 1'b1;
                    end
                  end
`endif
                  default: state_q <= S_IDLE;
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

  assign cmd.cmd_valid_o = valid_q;
  assign cmd.cmd_index_o = index_q;
  assign cmd.cmd_arg_o   = arg_q;
  assign cmd.cmd_resp_o  = resp_q;
  assign busy_o          = busy_q;
  assign init_done_o     = done_q;
  assign init_err_o      = fail_q;
  assign err_code_o      = err_q;
  assign ccs_o           = ccs_q;
  assign attempts_o      = attempts_q;
`ifdef SD_INIT_RCA_EN
  assign rca_o           = rca_q;
`else
  assign rca_o           = '0;
`endif
  assign unused_resp_bits = ^cmd.cmd_resp_i[29:12];

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Scoreboard bench for sd_init_sequencer: a responder model plays the CMD engine,
// a monitor pops expected commands/status as the DUT presents them.
`timescale 1ns/1ps
module tb_sd_init_sequencer;
  localparam int unsigned RETRY = 10;
  localparam int unsigned MAXA  = 4;
`ifdef SD_INIT_RCA_EN
  localparam logic [15:0] EXP_RCA = 16'hB368;
`else
  localparam logic [15:0] EXP_RCA = 16'h0000;
`endif

  typedef struct packed { logic [5:0] idx; logic [31:0] arg; logic [1:0] rsp; } cmd_t;
  typedef struct packed { logic to; logic [31:0] data; } rsp_t;
  typedef struct packed {
    logic done; logic err; logic [2:0] code; logic ccs; logic [15:0] att; logic [15:0] rca;
  } stat_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, idone, ierr, ccs;
  logic [2:0]  code;
  logic [15:0] att, rca;
  sd_init_sequencer_if bus();

  sd_init_sequencer #(.RETRY_WAIT_CYCLES(RETRY), .MAX_ATTEMPTS(MAXA)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cmd(bus.master),
    .busy_o(busy), .init_done_o(idone), .init_err_o(ierr), .err_code_o(code),
    .ccs_o(ccs), .attempts_o(att), .rca_o(rca)
  );

  always #5 clk = ~clk;

  cmd_t  exp_q[$];
  rsp_t  rsp_q[$];
  stat_t stat_q[$];
  int vectors = 0, miscompares = 0;
  int unsigned cyc = 0, done_cyc = 0;
  bit retry_pending = 1'b0;
  int ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: ready policy, spurious done during request phase, response after acceptance.
  initial begin : engine
    logic [5:0] idx;
    rsp_t r;
    bus.cmd_ready_i = 1'b0; bus.cmd_done_i = 1'b0; bus.cmd_timeout_i = 1'b0; bus.cmd_resp_i = '0;
    forever begin
      @(negedge clk);
      bus.cmd_done_i = 1'b0; bus.cmd_timeout_i = 1'b0;
      case (ready_mode)
        0:       bus.cmd_ready_i = 1'b1;
        1:       bus.cmd_ready_i = ($urandom_range(0, 2) != 0);
        default: bus.cmd_ready_i = 1'b0;
      endcase
      if (bus.cmd_valid_o && !bus.cmd_ready_i && ready_mode == 1) begin
        bus.cmd_done_i = 1'b1; bus.cmd_timeout_i = 1'b1; bus.cmd_resp_i = 32'hDEAD_BEEF;
      end else if (bus.cmd_valid_o && bus.cmd_ready_i && !rst) begin
        idx = bus.cmd_index_o;
        repeat (2) @(negedge clk);
        if (rsp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL engine_rsp: CMD%0d accepted, required no further command", idx);
          r = '{to: 1'b1, data: 32'h0};
        end else begin
          r = rsp_q.pop_front();
        end
        bus.cmd_done_i = 1'b1; bus.cmd_timeout_i = r.to; bus.cmd_resp_i = r.data;
        if (idx == 6'd41 && !r.to && !r.data[31]) begin
          retry_pending = 1'b1;
          done_cyc = cyc + 1;
        end
      end
    end
  end

  initial begin : monitor
    logic prev_valid, prev_busy;
    cmd_t act, e;
    stat_t st, es;
    prev_valid = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (bus.cmd_valid_o && !prev_valid && bus.cmd_index_o == 6'd55 && retry_pending) begin
          retry_pending = 1'b0;
          vectors++;
          if (cyc - done_cyc != RETRY + 1) begin
            miscompares++;
            $display("FAIL retry_gap: actual=%0d required=%0d", cyc - done_cyc, RETRY + 1);
          end
        end
        if (bus.cmd_valid_o && bus.cmd_ready_i) begin
          act = '{idx: bus.cmd_index_o, arg: bus.cmd_arg_o, rsp: bus.cmd_resp_o};
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL cmd_unexpected: actual idx=%0d arg=%h resp=%0d required=none",
                     act.idx, act.arg, act.rsp);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              miscompares++;
              $display("FAIL cmd: actual idx=%0d arg=%h resp=%0d required idx=%0d arg=%h resp=%0d",
                       act.idx, act.arg, act.rsp, e.idx, e.arg, e.rsp);
            end
          end
        end
        if (prev_busy && !busy) begin
          st = '{done: idone, err: ierr, code: code, ccs: ccs, att: att, rca: rca};
          vectors++;
          if (stat_q.size() == 0) begin
            miscompares++;
            $display("FAIL status_unexpected: actual=%h", st);
          end else begin
            es = stat_q.pop_front();
            if (st !== es) begin
              miscompares++;
              $display("FAIL status: actual done=%b err=%b code=%0d ccs=%b att=%0d rca=%h required done=%b err=%b code=%0d ccs=%b att=%0d rca=%h",
                       st.done, st.err, st.code, st.ccs, st.att, st.rca,
                       es.done, es.err, es.code, es.ccs, es.att, es.rca);
            end
          end
        end
      end
      prev_valid = bus.cmd_valid_o;
      prev_busy  = busy;
    end
  end

  task automatic step(input logic [5:0] i, input logic [31:0] a, input logic [1:0] r,
                      input logic to, input logic [31:0] d);
    exp_q.push_back('{idx: i, arg: a, rsp: r});
    rsp_q.push_back('{to: to, data: d});
  endtask

  task automatic expect_stat(input logic dn, input logic er, input logic [2:0] c,
                             input logic cc, input logic [15:0] at, input logic [15:0] ra);
    stat_q.push_back('{done: dn, err: er, code: c, ccs: cc, att: at, rca: ra});
  endtask

  task automatic ready_tail();
`ifdef SD_INIT_RCA_EN
    step(6'd2, 32'h0, 2'd2, 1'b0, 32'h1234_5678);
    step(6'd3, 32'h0, 2'd1, 1'b0, 32'hB368_0500);
`endif
  endtask

  task automatic run(input string name);
    int n;
    retry_pending = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (stat_q.size() != 0 && n < 2000) begin
      @(negedge clk); n++;
    end
    vectors++;
    if (stat_q.size() != 0 || exp_q.size() != 0 || rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL run_%s: pending status=%0d cmds=%0d rsps=%0d required 0/0/0",
               name, stat_q.size(), exp_q.size(), rsp_q.size());
      stat_q.delete(); exp_q.delete(); rsp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    logic [88:0] v;
    v = {busy, idone, ierr, code, ccs, att, rca, bus.cmd_valid_o, bus.cmd_index_o,
         bus.cmd_arg_o, bus.cmd_resp_o};
    vectors++;
    if (v !== '0) begin
      miscompares++;
      $display("FAIL %s: actual outputs=%h required all zero", name, v);
    end
  endtask

  task automatic sdhc_flow();
    step(6'd0,  32'h0,         2'd0, 1'b1, 32'h0);
    step(6'd8,  32'h0000_01AA, 2'd1, 1'b0, 32'h0000_01AA);
    step(6'd55, 32'h0,         2'd1, 1'b0, 32'h0000_0120);
    step(6'd41, 32'h4030_0000, 2'd1, 1'b0, 32'hC0FF_8000);
    ready_tail();
    expect_stat(1'b1, 1'b0, 3'd0, 1'b1, 16'd1, EXP_RCA);
    run("sdhc");
  endtask

  initial begin : stimulus
    int n;
    #1 check_zero("reset_hold");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1 check_zero("reset_release");

    sdhc_flow();

    ready_mode = 1;
    step(6'd0,  32'h0,         2'd0, 1'b0, 32'h0);
    step(6'd8,  32'h0000_01AA, 2'd1, 1'b1, 32'h0);
    step(6'd55, 32'h0,         2'd1, 1'b0, 32'h0000_0120);
    step(6'd41, 32'h0030_0000, 2'd1, 1'b0, 32'h80FF_8000);
    ready_tail();
    expect_stat(1'b1, 1'b0, 3'd0, 1'b0, 16'd1, EXP_RCA);
    run("legacy");
    ready_mode = 0;

    step(6'd0,  32'h0,         2'd0, 1'b0, 32'h0);
    step(6'd8,  32'h0000_01AA, 2'd1, 1'b0, 32'h0000_01AA);
    for (int i = 0; i < 2; i++) begin
      step(6'd55, 32'h0,         2'd1, 1'b0, 32'h0000_0120);
      step(6'd41, 32'h4030_0000, 2'd1, 1'b0, 32'h00FF_8000);
    end
    step(6'd55, 32'h0,         2'd1, 1'b0, 32'h0000_0120);
    step(6'd41, 32'h4030_0000, 2'd1, 1'b0, 32'hC0FF_8000);
    ready_tail();
    expect_stat(1'b1, 1'b0, 3'd0, 1'b1, 16'd3, EXP_RCA);
    run("busy_twice");

    step(6'd0,  32'h0,         2'd0, 1'b0, 32'h0);
    step(6'd8,  32'h0000_01AA, 2'd1, 1'b0, 32'h0000_01AA);
    for (int i = 0; i < 4; i++) begin
      step(6'd55, 32'h0,         2'd1, 1'b0, 32'h0000_0120);
      step(6'd41, 32'h4030_0000, 2'd1, 1'b0, 32'h00FF_8000);
    end
    expect_stat(1'b0, 1'b1, 3'd4, 1'b0, 16'd4, 16'h0);
    run("exhausted");

    step(6'd0,  32'h0,         2'd0, 1'b0, 32'h0);
    step(6'd8,  32'h0000_01AA, 2'd1, 1'b0, 32'h0000_01AB);
    expect_stat(1'b0, 1'b1, 3'd1, 1'b0, 16'd0, 16'h0);
    run("cmd8_echo");

    step(6'd0,  32'h0,         2'd0, 1'b0, 32'h0);
    step(6'd8,  32'h0000_01AA, 2'd1, 1'b0, 32'h0000_01AA);
    step(6'd55, 32'h0,         2'd1, 1'b1, 32'h0);
    expect_stat(1'b0, 1'b1, 3'd2, 1'b0, 16'd0, 16'h0);
    run("cmd55_timeout");

    step(6'd0,  32'h0,         2'd0, 1'b0, 32'h0);
    step(6'd8,  32'h0000_01AA, 2'd1, 1'b1, 32'h0);
    step(6'd55, 32'h0,         2'd1, 1'b0, 32'h0000_0120);
    step(6'd41, 32'h0030_0000, 2'd1, 1'b1, 32'h0);
    expect_stat(1'b0, 1'b1, 3'd3, 1'b0, 16'd1, 16'h0);
    run("acmd41_timeout");

`ifdef SD_INIT_RCA_EN
    step(6'd0,  32'h0,         2'd0, 1'b0, 32'h0);
    step(6'd8,  32'h0000_01AA, 2'd1, 1'b0, 32'h0000_01AA);
    step(6'd55, 32'h0,         2'd1, 1'b0, 32'h0000_0120);
    step(6'd41, 32'h4030_0000, 2'd1, 1'b0, 32'hC0FF_8000);
    step(6'd2,  32'h0,         2'd2, 1'b1, 32'h0);
    expect_stat(1'b0, 1'b1, 3'd5, 1'b1, 16'd1, 16'h0);
    run("cmd2_timeout");
`endif

    ready_mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!bus.cmd_valid_o && n < 20) begin
      @(negedge clk); n++;
    end
    vectors++;
    if (!bus.cmd_valid_o) begin
      miscompares++;
      $display("FAIL reset_setup: actual cmd_valid=0 required 1");
    end
    #2 rst = 1'b1;
    #1 check_zero("reset_mid_handshake");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    @(negedge clk); #1 check_zero("reset_idle_after_release");
    sdhc_flow();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sd_init_sequencer.md
# sd_init_sequencer

Sequences the SD card identification flow (CMD0, CMD8, CMD55/ACMD41 polling loop) by issuing commands to the SD command engine through a valid/ready request port and consuming its completion/response port. Sits above the CMD-line engine, which owns SDCLK, CRC7, serialisation and response capture. Reports card readiness, capacity class and errors to the host-side control logic.

## Interface
- RETRY_WAIT_CYCLES, 5000000: clk_i cycles between an ACMD41 "busy" response and the next CMD55. The default is 50 ms at 100 MHz.
- MAX_ATTEMPTS, 20: ACMD41 attempts before giving up. Range 1..65535.
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  begin initialisation; level sampled in IDLE/DONE/ERROR
- cmd_valid_o  out  1  command request valid
- cmd_ready_i  in  1  engine accepts request
- cmd_index_o  out  6  command index
- cmd_arg_o  out  32  command argument
- cmd_resp_o  out  2  expected response: 0 none, 1 48-bit, 2 136-bit
- cmd_done_i  in  1  one-cycle completion pulse from engine
- cmd_timeout_i  in  1  no response received; qualified by cmd_done_i
- cmd_resp_i  in  32  response bits [39:8]; valid with cmd_done_i
- busy_o  out  1  sequence in progress
- init_done_o  out  1  card ready (sticky until next start)
- init_err_o  out  1  sequence failed (sticky until next start)
- err_code_o  out  3  failure cause: 0 none, 1 CMD8 echo mismatch, 2 CMD55 timeout, 3 ACMD41 timeout, 4 attempts exhausted, 5 CMD2/CMD3 timeout
- ccs_o  out  1  card capacity status (OCR bit 30)
- attempts_o  out  16  ACMD41 attempts issued in the current run
- rca_o  out  16  relative card address (0 unless SD_INIT_RCA_EN)

## Operation
- States: IDLE, CMD0, CMD8, CMD55, ACMD41, RETRY_WAIT, [CMD2, CMD3], DONE, ERROR.
- Each command state has two phases. In the request phase, cmd_valid_o is high until cmd_ready_i is sampled high. In the wait phase, the sequencer waits for cmd_done_i.
- IDLE/DONE/ERROR with start_i=1: clear flags, err_code, ccs, attempts and rca, then go to CMD0. start_i is ignored in all other states.
- CMD0: index 0, arg 0, resp 0. Move to CMD8 on done; cmd_timeout_i is ignored.
- CMD8: index 8, arg 32'h000001AA, resp 1.
  - Timeout: legacy card, hcs=0, go to CMD55.
  - cmd_resp_i[11:0]==12'h1AA: hcs=1, go to CMD55.
  - Any other value: ERROR, code 1.
- CMD55: index 55, arg 0, resp 1. Timeout: ERROR, code 2. Otherwise go to ACMD41.
- ACMD41: index 41, arg hcs ? 32'h40300000 : 32'h00300000, resp 1. attempts_o increments at request acceptance.
  - Timeout: ERROR, code 3.
  - cmd_resp_i[31]=1: ccs_o=cmd_resp_i[30], go to CMD2 (SD_INIT_RCA_EN) or DONE.
  - cmd_resp_i[31]=0 with attempts_o==MAX_ATTEMPTS: ERROR, code 4.
  - cmd_resp_i[31]=0 otherwise: go to RETRY_WAIT.
- RETRY_WAIT: 32-bit down-counter loaded with RETRY_WAIT_CYCLES-1. Go to CMD55 when it reaches zero.
- DONE: init_done_o=1. ERROR: init_err_o=1. busy_o=1 in every state except IDLE/DONE/ERROR.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset is asynchronous, so it takes effect immediately, including mid-handshake. After reset release, a new start_i is required.
- All outputs are registered.
- cmd_valid_o rises on the cycle after the state is entered. index/arg/resp are stable from that cycle until acceptance.
- cmd_done_i arriving in the request phase is ignored. Only the wait phase consumes it.
- On cmd_done_i, the next state and any flag/code updates are visible on the following cycle.
- CMD55 cmd_valid_o rises exactly RETRY_WAIT_CYCLES+1 cycles after the busy ACMD41 done pulse.
- If cmd_ready_i is held high permanently, the request phase lasts exactly 1 cycle.

## Configuration
- SD_INIT_RCA_EN defined: CMD2 (index 2, arg 0, resp 2) and then CMD3 (index 3, arg 0, resp 1) run after ACMD41 ready. rca_o is loaded from cmd_resp_i[31:16] on CMD3 done. A timeout on either command goes to ERROR with code 5.
- SD_INIT_RCA_EN undefined: CMD2/CMD3 logic is not compiled in. ACMD41 ready goes directly to DONE, and rca_o is tied to 0.

## Test plan
- SDHC card: CMD8 resp 32'h000001AA, first ACMD41 resp 32'hC0FF8000 -> command order 0,8,55,41; ACMD41 arg 32'h40300000; init_done_o=1, ccs_o=1, attempts_o=1.
- Legacy card: CMD8 timeout -> ACMD41 arg 32'h00300000; with ready resp 32'h80FF8000 -> done, ccs_o=0.
- Busy twice then ready, RETRY_WAIT_CYCLES=10 -> attempts_o=3, each CMD55 valid 11 cycles after the busy done pulse.
- Always busy, MAX_ATTEMPTS=4 -> init_err_o=1, err_code_o=4, attempts_o=4. CMD8 resp 32'h000001AB -> err_code_o=1.
- rst_i asserted while cmd_valid_o=1 -> all outputs 0 immediately; start_i after release restarts at CMD0.
- SD_INIT_RCA_EN, CMD3 resp 32'hB3680500 -> rca_o=16'hB368; CMD2 issued with cmd_resp_o=2.
